t02_wishbone_arbiter: RTL and testbench
=======================================

# t02_wishbone_arbiter

Parametrised Wishbone classic-cycle manager that arbitrates NUM_REQ independent requesters (CPU data port, instruction fetch, LCD/keypad DMA) onto one Wishbone bus. It supersedes the single-requester manager in the team_02 wrapper and adds:
- round-robin arbitration;
- per-requester byte select;
- bus timeout with an error pulse;
- a global enable.

It sits between the t02 core-side masters and the caravel Wishbone port.

## Interface
- NUM_REQ, 2, number of requester channels (1..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8); SEL_W = DATA_W/8
- TIMEOUT_CYCLES, 255, maximum cycles STB_O is held without ACK_I; 0 disables timeout
---
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- en  in  1  enable; low blocks new grants, in-flight cycle completes
- req_adr  in  NUM_REQ*ADDR_W  per-requester address, slice i = channel i
- req_wdat  in  NUM_REQ*DATA_W  per-requester write data
- req_sel  in  NUM_REQ*SEL_W  per-requester byte select
- req_we  in  NUM_REQ  write request
- req_re  in  NUM_REQ  read request
- req_rdat  out  DATA_W  read data, shared, valid with req_done
- req_busy  out  NUM_REQ  channel has an outstanding request not yet completed
- req_done  out  NUM_REQ  one-cycle completion pulse
- req_err  out  NUM_REQ  one-cycle timeout pulse, coincident with req_done
- ADR_O  out  ADDR_W  bus address
- DAT_O  out  DATA_W  bus write data
- SEL_O  out  SEL_W  bus byte select
- WE_O  out  1  bus write enable
- STB_O  out  1  bus strobe
- CYC_O  out  1  bus cycle
- DAT_I  in  DATA_W  bus read data
- ACK_I  in  1  bus acknowledge

## Operation
- Request i is active when req_we[i] or req_re[i] is high. If both are high, the request is treated as a write.
- A requester holds adr/wdat/sel/we/re stable from assertion until it sees req_done[i]. It drops the request in the cycle after done; otherwise a new transaction is started.
- FSM states: IDLE, BUS, DONE.
- IDLE → BUS:
  - Taken when en=1 and any request is active.
  - Grant is the first active channel searching from last_grant+1 upward, wrapping at NUM_REQ.
  - Latches the channel's adr, wdat, sel and we into ADR_O, DAT_O, SEL_O, WE_O.
  - Sets STB_O = CYC_O = 1, clears the timeout counter and updates last_grant.
- BUS → DONE on ACK_I. On a read, DAT_I is latched into req_rdat in the same edge. STB_O, CYC_O and WE_O clear.
- BUS → DONE on timeout, i.e. counter == TIMEOUT_CYCLES-1 with no ACK_I. STB_O and CYC_O clear. req_rdat is unchanged and an error is flagged.
- ACK wins over a timeout in the same cycle.
- DONE → IDLE unconditionally. In DONE, req_done[grant] = 1, and req_err[grant] = 1 if the transaction timed out.
- req_busy[i] = active[i] & ~req_done[i], combinational.
- ACK_I is ignored outside BUS.
- en low in BUS or DONE has no effect; the transaction finishes normally.
- ADR_O, DAT_O and SEL_O hold their last values after a cycle ends.

## Timing
- All outputs are registered except req_busy.
- Reset values:
  - last_grant = NUM_REQ-1, so channel 0 wins first.
  - STB_O, CYC_O, WE_O = 0.
  - ADR_O, DAT_O, SEL_O, req_rdat = 0.
  - req_done, req_err = 0; state = IDLE.
- Reset mid-cycle drops STB_O and CYC_O immediately (asynchronous). No done or err pulse is generated.
- Latency: request sampled at edge k gives STB_O high in cycle k+1. ACK sampled at edge m gives req_done in cycle m+1. Zero-wait slave: 3 cycles from request to done, next grant possible 1 cycle later.
- Timeout: STB_O is high for exactly TIMEOUT_CYCLES cycles before the abort.
- Timeout counter width is clog2(TIMEOUT_CYCLES+1) and it saturates, never wraps.
- Back-to-back contention: with every channel continuously active, grants rotate 0,1,…,NUM_REQ-1,0.

## Test plan
- Single read: NUM_REQ=2, ch0 req_re, adr=0x3300_0010, slave ACK 2 cycles after STB with DAT_I=0xCAFE_F00D -> ADR_O=0x3300_0010, WE_O=0, one req_done[0] pulse, req_rdat=0xCAFE_F00D, req_busy[0] low after done.
- Byte write: ch1 req_we, sel=4'b0010, wdat=0x0000_AB00 -> SEL_O=0x2, DAT_O=0x0000_AB00, WE_O=1 for the whole STB, req_done[1] only.
- Contention: ch0 and ch1 held active from reset, zero-wait slave, requesters re-request after done -> grant order 0,1,0,1. No STB gap longer than 2 cycles.
- Timeout: TIMEOUT_CYCLES=8, no ACK -> STB_O high exactly 8 cycles, then req_done and req_err pulse together, req_rdat unchanged. Late ACK_I in IDLE is ignored.
- Reset mid-cycle: assert nrst=0 during BUS -> STB_O, CYC_O, WE_O drop without waiting for clk, no done pulse. After release, ch0 is granted first.
- Enable: en=0 with ch0 active -> STB_O stays 0. Drop en during BUS -> cycle completes with done. Raise en -> pending request is granted next cycle.

Source files
------------

// File: rtl/t02_wishbone_arbiter.sv
// Round-robin Wishbone classic-cycle manager: NUM_REQ requesters share one bus,
// with per-requester byte select, a bus timeout that aborts with an error pulse, and a global enable.
module t02_wishbone_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      en,
    input  logic [NUM_REQ*ADDR_W-1:0] req_adr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdat,
    input  logic [NUM_REQ*(DATA_W/8)-1:0] req_sel,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_re,
    output logic [DATA_W-1:0]         req_rdat,
    output logic [NUM_REQ-1:0]        req_busy,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [NUM_REQ-1:0]        req_err,
    output logic [ADDR_W-1:0]         ADR_O,
    output logic [DATA_W-1:0]         DAT_O,
    output logic [DATA_W/8-1:0]       SEL_O,
    output logic                      WE_O,
    output logic                      STB_O,
    output logic                      CYC_O,
    input  logic [DATA_W-1:0]         DAT_I,
    input  logic                      ACK_I
);

    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned GNT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_e;

    state_e              state_q, state_d;
    logic [GNT_W-1:0]    last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                we_q, we_d;
    logic                stb_q, stb_d;
    logic                cyc_q, cyc_d;
    logic [DATA_W-1:0]   rdat_q, rdat_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [NUM_REQ-1:0]  err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_REQ-1:0]  active;
    logic                gnt_found;
    logic [GNT_W-1:0]    gnt_idx;
    int unsigned         cand;
    logic                timeout_hit;

    assign active      = req_we | req_re;
    assign req_busy    = active & ~done_q;
    assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

    // Round-robin search starting one past the last granted channel
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = last_grant_q;
        cand      = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = (32'(last_grant_q) + off) % NUM_REQ;
            if (!gnt_found && active[GNT_W'(cand)]) begin
                gnt_found = 1'b1;
                gnt_idx   = GNT_W'(cand);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        we_d         = we_q;
        stb_d        = stb_q;
        cyc_d        = cyc_q;
        rdat_d       = rdat_q;
        cnt_d        = cnt_q;
        done_d       = '0;
        err_d        = '0;
        case (state_q)
            IDLE: begin
                if (en && gnt_found) begin
                    state_d      = BUS;
                    last_grant_d = gnt_idx;
                    adr_d        = req_adr[gnt_idx*ADDR_W +: ADDR_W];
                    dat_d        = req_wdat[gnt_idx*DATA_W +: DATA_W];
                    sel_d        = req_sel[gnt_idx*SEL_W +: SEL_W];
                    we_d         = req_we[gnt_idx];
                    stb_d        = 1'b1;
                    cyc_d        = 1'b1;
                    cnt_d        = '0;
                end
            end
            BUS: begin
                // ACK takes priority over a timeout landing in the same cycle
                if (ACK_I) begin
                    state_d              = DONE;
                    stb_d                = 1'b0;
                    cyc_d                = 1'b0;
                    we_d                 = 1'b0;
                    done_d[last_grant_q] = 1'b1;
                    if (!we_q) begin
                        rdat_d = DAT_I;
                    end
                end else if (timeout_hit) begin
                    state_d              = DONE;
                    stb_d                = 1'b0;
                    cyc_d                = 1'b0;
                    done_d[last_grant_q] = 1'b1;
                    err_d[last_grant_q]  = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_W'(NUM_REQ - 1);
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            stb_q        <= 1'b0;
            cyc_q        <= 1'b0;
            rdat_q       <= '0;
            done_q       <= '0;
            err_q        <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            stb_q        <= stb_d;
            cyc_q        <= cyc_d;
            rdat_q       <= rdat_d;
            done_q       <= done_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign ADR_O    = adr_q;
    assign DAT_O    = dat_q;
    assign SEL_O    = sel_q;
    assign WE_O     = we_q;
    assign STB_O    = stb_q;
    assign CYC_O    = cyc_q;
    assign req_rdat = rdat_q;
    assign req_done = done_q;
    assign req_err  = err_q;

endmodule

// File: tb/tb_t02_wishbone_arbiter.sv
// Directed bench for t02_wishbone_arbiter: read, byte write, timeout, enable gating,
// asynchronous reset mid-cycle and round-robin contention, with hand-computed expectations.
module tb_t02_wishbone_arbiter;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SEL_W   = DATA_W / 8;

    logic                      clk;
    logic                      nrst;
    logic                      en;
    logic [NUM_REQ*ADDR_W-1:0] req_adr;
    logic [NUM_REQ*DATA_W-1:0] req_wdat;
    logic [NUM_REQ*SEL_W-1:0]  req_sel;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ-1:0]        req_re;
    logic [DATA_W-1:0]         req_rdat;
    logic [NUM_REQ-1:0]        req_busy;
    logic [NUM_REQ-1:0]        req_done;
    logic [NUM_REQ-1:0]        req_err;
    logic [ADDR_W-1:0]         ADR_O;
    logic [DATA_W-1:0]         DAT_O;
    logic [SEL_W-1:0]          SEL_O;
    logic                      WE_O;
    logic                      STB_O;
    logic                      CYC_O;
    logic [DATA_W-1:0]         DAT_I;
    logic                      ACK_I;

    int n_checks;
    int n_fail;

    t02_wishbone_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .en       (en),
        .req_adr  (req_adr),
        .req_wdat (req_wdat),
        .req_sel  (req_sel),
        .req_we   (req_we),
        .req_re   (req_re),
        .req_rdat (req_rdat),
        .req_busy (req_busy),
        .req_done (req_done),
        .req_err  (req_err),
        .ADR_O    (ADR_O),
        .DAT_O    (DAT_O),
        .SEL_O    (SEL_O),
        .WE_O     (WE_O),
        .STB_O    (STB_O),
        .CYC_O    (CYC_O),
        .DAT_I    (DAT_I),
        .ACK_I    (ACK_I)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nrst     = 1'b0;
        en       = 1'b0;
        req_adr  = '0;
        req_wdat = '0;
        req_sel  = '0;
        req_we   = '0;
        req_re   = '0;
        DAT_I    = '0;
        ACK_I    = 1'b0;
        tick();
        tick();
        chk("rst_stb",  64'(STB_O), 64'(0));
        chk("rst_cyc",  64'(CYC_O), 64'(0));
        chk("rst_we",   64'(WE_O), 64'(0));
        chk("rst_adr",  64'(ADR_O), 64'(0));
        chk("rst_rdat", 64'(req_rdat), 64'(0));
        chk("rst_done", 64'(req_done), 64'(0));
        nrst = 1'b1;
        en   = 1'b1;
        tick();

        // Single read on ch0, ACK after two wait cycles
        req_adr[31:0] = 32'h3300_0010;
        req_sel[3:0]  = 4'hF;
        req_re        = 2'b01;
        DAT_I         = 32'hCAFE_F00D;
        tick();
        chk("rd_stb",  64'(STB_O), 64'(1));
        chk("rd_cyc",  64'(CYC_O), 64'(1));
        chk("rd_adr",  64'(ADR_O), 64'h3300_0010);
        chk("rd_we",   64'(WE_O), 64'(0));
        chk("rd_busy", 64'(req_busy), 64'(1));
        tick();
        tick();
        chk("rd_wait_stb",  64'(STB_O), 64'(1));
        chk("rd_wait_done", 64'(req_done), 64'(0));
        ACK_I = 1'b1;
        tick();
        ACK_I = 1'b0;
        DAT_I = 32'h1111_2222;
        chk("rd_done",      64'(req_done), 64'(1));
        chk("rd_err",       64'(req_err), 64'(0));
        chk("rd_rdat",      64'(req_rdat), 64'hCAFE_F00D);
        chk("rd_stb_off",   64'(STB_O), 64'(0));
        chk("rd_busy_done", 64'(req_busy), 64'(0));
        req_re = 2'b00;
        tick();
        chk("rd_done_pulse", 64'(req_done), 64'(0));
        chk("rd_busy_idle",  64'(req_busy), 64'(0));

        // Byte write on ch1
        req_adr[63:32]  = 32'h3300_0020;
        req_wdat[63:32] = 32'h0000_AB00;
        req_sel[7:4]    = 4'b0010;
        req_we          = 2'b10;
        tick();
        chk("wr_stb",  64'(STB_O), 64'(1));
        chk("wr_adr",  64'(ADR_O), 64'h3300_0020);
        chk("wr_sel",  64'(SEL_O), 64'h2);
        chk("wr_dat",  64'(DAT_O), 64'h0000_AB00);
        chk("wr_we0",  64'(WE_O), 64'(1));
        chk("wr_busy", 64'(req_busy), 64'(2));
        tick();
        chk("wr_we1",  64'(WE_O), 64'(1));
        ACK_I = 1'b1;
        tick();
        ACK_I = 1'b0;
        chk("wr_done",    64'(req_done), 64'(2));
        chk("wr_rdat",    64'(req_rdat), 64'hCAFE_F00D);
        chk("wr_we_off",  64'(WE_O), 64'(0));
        chk("wr_sel_hold", 64'(SEL_O), 64'h2);
        req_we = 2'b00;
        tick();

        // Timeout: no ACK, STB must stay high exactly 8 cycles
        req_adr[31:0] = 32'h3300_0030;
        req_re        = 2'b01;
        tick();
        chk("to_stb_0", 64'(STB_O), 64'(1));
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("to_stb_%0d", i), 64'(STB_O), 64'(1));
            chk($sformatf("to_nodone_%0d", i), 64'(req_done), 64'(0));
        end
        tick();
        chk("to_stb_off", 64'(STB_O), 64'(0));
        chk("to_cyc_off", 64'(CYC_O), 64'(0));
        chk("to_done",    64'(req_done), 64'(1));
        chk("to_err",     64'(req_err), 64'(1));
        chk("to_rdat",    64'(req_rdat), 64'hCAFE_F00D);
        req_re = 2'b00;
        ACK_I  = 1'b1;
        tick();
        chk("to_err_pulse", 64'(req_err), 64'(0));
        tick();
        chk("late_ack_stb",  64'(STB_O), 64'(0));
        chk("late_ack_done", 64'(req_done), 64'(0));
        chk("late_ack_rdat", 64'(req_rdat), 64'hCAFE_F00D);
        ACK_I = 1'b0;

        // Enable gating
        en            = 1'b0;
        req_adr[31:0] = 32'h3300_0040;
        req_re        = 2'b01;
        tick();
        chk("en_off_stb0", 64'(STB_O), 64'(0));
        tick();
        chk("en_off_stb1", 64'(STB_O), 64'(0));
        chk("en_off_busy", 64'(req_busy), 64'(1));
        en = 1'b1;
        tick();
        chk("en_on_stb", 64'(STB_O), 64'(1));
        chk("en_on_adr", 64'(ADR_O), 64'h3300_0040);
        en = 1'b0;
        tick();
        chk("en_drop_stb", 64'(STB_O), 64'(1));
        ACK_I = 1'b1;
        tick();
        ACK_I = 1'b0;
        chk("en_drop_done", 64'(req_done), 64'(1));
        req_re = 2'b00;
        en     = 1'b1;
        tick();

        // Asynchronous reset in the middle of a write cycle on ch1
        req_adr[63:32] = 32'h3300_0050;
        req_sel[7:4]   = 4'hF;
        req_we         = 2'b10;
        tick();
        chk("rm_stb", 64'(STB_O), 64'(1));
        chk("rm_we",  64'(WE_O), 64'(1));
        chk("rm_adr", 64'(ADR_O), 64'h3300_0050);
        #3;
        nrst = 1'b0;
        #1;
        chk("rm_stb_drop", 64'(STB_O), 64'(0));
        chk("rm_cyc_drop", 64'(CYC_O), 64'(0));
        chk("rm_we_drop",  64'(WE_O), 64'(0));
        chk("rm_no_done",  64'(req_done), 64'(0));

        // Contention with a zero-wait slave: ch0 first after reset, then alternate
        req_adr[31:0] = 32'h3300_0060;
        req_re        = 2'b01;
        ACK_I         = 1'b1;
        tick();
        chk("rm_no_done_hold", 64'(req_done), 64'(0));
        nrst = 1'b1;
        for (int r = 0; r < 4; r++) begin
            tick();
            chk($sformatf("ct_stb_%0d", r), 64'(STB_O), 64'(1));
            chk($sformatf("ct_adr_%0d", r), 64'(ADR_O),
                (r % 2 == 0) ? 64'h3300_0060 : 64'h3300_0050);
            chk($sformatf("ct_we_%0d", r), 64'(WE_O), (r % 2 == 0) ? 64'(0) : 64'(1));
            tick();
            chk($sformatf("ct_done_%0d", r), 64'(req_done), (r % 2 == 0) ? 64'(1) : 64'(2));
            chk($sformatf("ct_gap1_%0d", r), 64'(STB_O), 64'(0));
            tick();
            chk($sformatf("ct_gap2_%0d", r), 64'(STB_O), 64'(0));
            chk($sformatf("ct_idle_done_%0d", r), 64'(req_done), 64'(0));
        end
        req_re = 2'b00;
        req_we = 2'b00;
        ACK_I  = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
